data_mem_responder: RTL and testbench

Data-side memory responder for the 5-stage MIPS core; it sits at the far end of the M-stage data port and services the core's memory requests. It accepts address, byte-lane write enables and lane-replicated write data, and stores data into an internal byte-lane RAM. Read data is returned with a configurable number of wait states. It drives a stall request into the hazard unit so the M stage holds until the response cycle.

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_byte_bank.sv | 35 +++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-side memory responder: FSM states and the
// byte-lane write-enable codes the M stage can present.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WEN_NONE    = 4'b0000;
    localparam logic [3:0] WEN_BYTE0   = 4'b0001;
    localparam logic [3:0] WEN_BYTE1   = 4'b0010;
    localparam logic [3:0] WEN_BYTE2   = 4'b0100;
    localparam logic [3:0] WEN_BYTE3   = 4'b1000;
    localparam logic [3:0] WEN_HALF_LO = 4'b0011;
    localparam logic [3:0] WEN_HALF_HI = 4'b1100;
    localparam logic [3:0] WEN_WORD    = 4'b1111;

endpackage

// File: rtl/data_mem_responder_byte_bank.sv
// One byte lane of the data RAM: synchronous write, registered
// read-before-write. The read register clears on reset and can be forced
// to zero for a rejected access; the array itself is never reset.
module dmem_byte_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Lane write on the access edge.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read of the pre-write contents; holds between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'd0;
        end else if (en) begin
            rdata <= clr ? 8'd0 : mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder for the M stage. Counts WAIT_CYCLES wait
// states, performs one read-before-write access on four byte banks, and
// stalls the core until the single response cycle.
// Optional feature: define DMEM_ERR_CHECK_EN to reject out-of-range,
// misaligned or illegal-wen accesses (addr_err_o); otherwise addresses
// wrap and every wen pattern is written as given.
// state_o exposes the FSM state for checkers.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        resp_o,
    output logic        addr_err_o,
    output logic [1:0]  state_o
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state, stateNext;
    logic [3:0]        waitCnt, waitCntNext;
    logic              accessNow;
    logic              accessErr;
    logic              bankEn;
    logic [ADDR_W-1:0] wordIdx;

    assign wordIdx = addr_i[ADDR_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    logic highBad;
    logic wenBad;

    // Reject addresses beyond capacity, misaligned halves/words and
    // wen codes the core never legally produces.
    always_comb begin
        highBad = (addr_i >> (ADDR_W + 2)) != 32'd0;
        wenBad  = 1'b0;
        case (wen_i)
            WEN_NONE, WEN_BYTE0, WEN_BYTE1, WEN_BYTE2, WEN_BYTE3: wenBad = 1'b0;
            WEN_HALF_LO, WEN_HALF_HI:                             wenBad = addr_i[0];
            WEN_WORD:                                             wenBad = (addr_i[1:0] != 2'b00);
            default:                                              wenBad = 1'b1;
        endcase
    end

    assign accessErr = highBad | wenBad;
`else
    // High address bits and lane bits are ignored: the address wraps.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
    assign accessErr      = 1'b0;
`endif

    // Next-state logic: wait-state countdown, then one access edge into RESP.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accessNow   = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        accessNow = 1'b1;
                    end else begin
                        stateNext   = BUSY;
                        waitCntNext = WAIT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (waitCnt != 4'd0) begin
                    waitCntNext = waitCnt - 4'd1;
                end else begin
                    stateNext = RESP;
                    accessNow = 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, counter and error flag registers; reset drops any pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            addr_err_o <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (accessNow) begin
                addr_err_o <= accessErr;
            end
        end
    end

    assign bankEn  = accessNow & ~rst;
    assign stall_o = req_i & (state != RESP) & ~rst;
    assign resp_o  = (state == RESP);
    assign state_o = state;

    for (genvar k = 0; k < 4; k++) begin : bankGen
        dmem_byte_bank #(.ADDR_W(ADDR_W)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (bankEn),
            .we    (wen_i[k] & ~accessErr),
            .clr   (accessErr),
            .addr  (wordIdx),
            .wdata (wdata_i[8*k +: 8]),
            .rdata (rdata_o[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Three instances (WAIT_CYCLES 0, 1
// and 3) share one stimulus bus; each test selects the instance it checks.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata [3];
    logic        stall [3];
    logic        resp  [3];
    logic        err   [3];
    logic [1:0]  st    [3];

    int checkCount = 0;
    int errCount   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata[0]), .stall_o(stall[0]), .resp_o(resp[0]), .addr_err_o(err[0]), .state_o(st[0])
    );
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata[1]), .stall_o(stall[1]), .resp_o(resp[1]), .addr_err_o(err[1]), .state_o(st[1])
    );
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata[2]), .stall_o(stall[2]), .resp_o(resp[2]), .addr_err_o(err[2]), .state_o(st[2])
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access on instance sel: waits for all instances to be idle, drives
    // the request, counts stalled cycles until resp, then drops the request
    // and confirms resp lasts one cycle followed by IDLE.
    task automatic doAccess(input int sel, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd,
                            output logic e, output int stallCnt);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            if (st[0] == 2'd0 && st[1] == 2'd0 && st[2] == 2'd0) break;
            @(posedge clk); #1;
        end
        @(negedge clk);
        req = 1'b1; wen = w; addr = a; wdata = d;
        stallCnt = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (stall[sel]) stallCnt++;
            if (resp[sel]) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkVal("resp_seen", 32'(got), 32'd1);
        rd = rdata[sel];
        e  = err[sel];
        req = 1'b0; wen = 4'b0000;
        @(posedge clk); #1;
        checkVal("resp_one_cycle", 32'(resp[sel]), 32'd0);
        checkVal("idle_after_resp", 32'(st[sel]), 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          sc;

    initial begin
        rst = 1'b1; req = 1'b0; wen = 4'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req = 1'b1;
        #1;
        checkVal("rst_stall", 32'(stall[1]), 32'd0);
        checkVal("rst_resp",  32'(resp[1]),  32'd0);
        checkVal("rst_rdata", rdata[1],      32'd0);
        checkVal("rst_err",   32'(err[1]),   32'd0);
        checkVal("rst_state", 32'(st[1]),    32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Word store then load, one wait state.
        doAccess(1, 4'b1111, 32'h10, 32'hDEADBEEF, rd, e, sc);
        checkVal("word_st_stall", 32'(sc), 32'd2);
        doAccess(1, 4'b0000, 32'h10, 32'h0, rd, e, sc);
        checkVal("word_ld_stall", 32'(sc), 32'd2);
        checkVal("word_ld_data", rd, 32'hDEADBEEF);
        checkVal("word_ld_err", 32'(e), 32'd0);

        // Byte store into lane 2.
        doAccess(1, 4'b0100, 32'h12, 32'h55555555, rd, e, sc);
        checkVal("byte_st_rbw", rd, 32'hDEADBEEF);
        doAccess(1, 4'b0000, 32'h10, 32'h0, rd, e, sc);
        checkVal("byte_ld_data", rd, 32'hDE55BEEF);

        // Half store into the upper half of a zeroed word.
        doAccess(1, 4'b1111, 32'h20, 32'h0, rd, e, sc);
        doAccess(1, 4'b1100, 32'h22, 32'hABCDABCD, rd, e, sc);
        doAccess(1, 4'b0000, 32'h20, 32'h0, rd, e, sc);
        checkVal("half_ld_data", rd, 32'hABCD0000);

`ifdef DMEM_ERR_CHECK_EN
        doAccess(1, 4'b1111, 32'h11, 32'h12345678, rd, e, sc);
        checkVal("err_misalign_flag", 32'(e), 32'd1);
        checkVal("err_misalign_stall", 32'(sc), 32'd2);
        doAccess(1, 4'b0000, 32'h10, 32'h0, rd, e, sc);
        checkVal("err_mem_unchanged", rd, 32'hDE55BEEF);
        checkVal("err_clear_flag", 32'(e), 32'd0);
        doAccess(1, 4'b0000, 32'h1000, 32'h0, rd, e, sc);
        checkVal("err_range_flag", 32'(e), 32'd1);
        checkVal("err_range_data", rd, 32'd0);
`endif

        // Reset in the middle of a store, three wait states.
        doAccess(2, 4'b1111, 32'h30, 32'h11111111, rd, e, sc);
        checkVal("w3_st_stall", 32'(sc), 32'd4);
        doAccess(2, 4'b0000, 32'h30, 32'h0, rd, e, sc);
        checkVal("w3_ld_data", rd, 32'h11111111);
        @(negedge clk);
        req = 1'b1; wen = 4'b1111; addr = 32'h30; wdata = 32'h99999999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkVal("mid_busy_state", 32'(st[2]), 32'd1);
        rst = 1'b1;
        #1;
        checkVal("mid_rst_stall_comb", 32'(stall[2]), 32'd0);
        @(posedge clk); #1;
        checkVal("mid_rst_state", 32'(st[2]), 32'd0);
        checkVal("mid_rst_resp",  32'(resp[2]), 32'd0);
        checkVal("mid_rst_rdata", rdata[2], 32'd0);
        checkVal("mid_rst_stall", 32'(stall[2]), 32'd0);
        rst = 1'b0; req = 1'b0; wen = 4'b0000;
        @(posedge clk); #1;
        doAccess(2, 4'b0000, 32'h30, 32'h0, rd, e, sc);
        checkVal("mid_rst_old_val", rd, 32'h11111111);

        // Latency sweep.
        doAccess(0, 4'b1111, 32'h40, 32'hCAFEF00D, rd, e, sc);
        checkVal("w0_st_stall", 32'(sc), 32'd1);
        doAccess(0, 4'b0000, 32'h40, 32'h0, rd, e, sc);
        checkVal("w0_ld_stall", 32'(sc), 32'd1);
        checkVal("w0_ld_data", rd, 32'hCAFEF00D);
        doAccess(2, 4'b0000, 32'h30, 32'h0, rd, e, sc);
        checkVal("w3_ld_stall", 32'(sc), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
